// File: rtl/programmable_diff_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : programmable_diff_delay_line
// Purpose  : Multi-lane differential delay line with a delay that can be
//            changed at runtime. Each lane's (in_p, in_n) pair is delayed
//            by o_delay_cur clock cycles (1..MAX_DELAY). A req/ack handshake
//            loads a new delay. The outputs are blanked to the idle
//            differential level (p=0, n=1) while the line refills.
// Options  : `define PAIR_CHECK_EN builds the pair-error checker. This
//            counts cycles where in_p == in_n on any lane and keeps a
//            sticky flag. Without it, err outputs are constant zero.
// Ports    : i_clk        clock, all state updates on posedge
//            i_rst        asynchronous active-high reset
//            i_in_p/n     positive / negative leg, one bit per lane
//            o_out_p/n    delayed legs (idle while o_out_valid=0)
//            o_out_valid  1 = outputs carry delayed data
//            i_delay_req  level request, held until o_delay_ack
//            i_delay_val  requested delay (clamped to 1..MAX_DELAY)
//            o_delay_ack  one-cycle acceptance pulse
//            o_delay_cur  delay currently applied
//            i_err_clr    clears err count/flag
//            o_err_count  saturating pair-error cycle count
//            o_err_flag   sticky pair-error flag
// Revision : 1.0 - initial release
// ============================================================================
module programmable_diff_delay_line #(
    parameter int LANES      = 4,
    parameter int MAX_DELAY  = 16,
    parameter int DELAY_INIT = 5,
    parameter int DW         = $clog2(MAX_DELAY + 1),
    parameter int ERR_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [LANES-1:0] i_in_p,
    input  logic [LANES-1:0] i_in_n,
    output logic [LANES-1:0] o_out_p,
    output logic [LANES-1:0] o_out_n,
    output logic             o_out_valid,
    input  logic             i_delay_req,
    input  logic [DW-1:0]    i_delay_val,
    output logic             o_delay_ack,
    output logic [DW-1:0]    o_delay_cur,
    input  logic             i_err_clr,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_err_flag
);

    localparam logic [DW-1:0] C_DELAY_INIT = DW'(DELAY_INIT);
    localparam logic [DW-1:0] C_MAX_DELAY  = DW'(MAX_DELAY);
    localparam logic [DW-1:0] C_ONE        = DW'(1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_settle_cnt;
    logic [DW-1:0]    w_settle_cnt_nxt;
    logic [DW-1:0]    r_delay_cur;
    logic [DW-1:0]    w_delay_cur_nxt;
    logic             w_valid;
    logic             w_ack;
    logic             w_settled;

    logic [LANES-1:0] r_stage_p [MAX_DELAY];
    logic [LANES-1:0] r_stage_n [MAX_DELAY];
    logic [LANES-1:0] w_tap_p;
    logic [LANES-1:0] w_tap_n;
    logic [DW-1:0]    w_tap_idx;

    // Force a requested delay into the legal range 1..MAX_DELAY.
    function automatic logic [DW-1:0] f_clamp(input logic [DW-1:0] val);
        logic [DW-1:0] res;
        res = val;
        if (val == '0) begin
            res = C_ONE;
        end else if (val > C_MAX_DELAY) begin
            res = C_MAX_DELAY;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Shift chain: free-running in every state. Reset loads the idle
    // differential level so nothing non-idle is ever tapped.
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < MAX_DELAY; k++) begin : g_stage
            if (k == 0) begin : g_head
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        r_stage_p[k] <= '0;
                        r_stage_n[k] <= '1;
                    end else begin
                        r_stage_p[k] <= i_in_p;
                        r_stage_n[k] <= i_in_n;
                    end
                end
            end else begin : g_body
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        r_stage_p[k] <= '0;
                        r_stage_n[k] <= '1;
                    end else begin
                        r_stage_p[k] <= r_stage_p[k-1];
                        r_stage_n[k] <= r_stage_n[k-1];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tap select. stage[d-1] holds the input sampled d edges ago, so the
    // tap gives a latency of exactly d cycles. Built as a compare-and-select
    // so the DW-bit delay never indexes the array directly.
    // ------------------------------------------------------------------
    assign w_tap_idx = r_delay_cur - C_ONE;

    always_comb begin
        w_tap_p = '0;
        w_tap_n = '1;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (w_tap_idx == DW'(k)) begin
                w_tap_p = r_stage_p[k];
                w_tap_n = r_stage_n[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // FILL and SETTLE both wait delay_cur cycles. That is long enough for
    // the whole tapped depth to hold post-reset / post-change input.
    assign w_settled = (r_settle_cnt == (r_delay_cur - C_ONE));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_FILL;
            r_settle_cnt <= '0;
            r_delay_cur  <= C_DELAY_INIT;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_delay_cur  <= w_delay_cur_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_delay_cur_nxt  = r_delay_cur;
        w_valid          = 1'b0;
        w_ack            = 1'b0;
        case (r_state)
            ST_FILL, ST_SETTLE: begin
                // Requests are not looked at here. The requester keeps
                // holding, and the request is taken in the first RUN cycle.
                if (w_settled) begin
                    w_state_nxt      = ST_RUN;
                    w_settle_cnt_nxt = '0;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + C_ONE;
                end
            end
            ST_RUN: begin
                w_valid = 1'b1;
                if (i_delay_req) begin
                    // A same-value request also goes through the full
                    // settle sequence, so software sees uniform behaviour.
                    w_ack            = 1'b1;
                    w_delay_cur_nxt  = f_clamp(i_delay_val);
                    w_settle_cnt_nxt = '0;
                    w_state_nxt      = ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt      = ST_FILL;
                w_settle_cnt_nxt = '0;
            end
        endcase
    end

    assign o_out_valid = w_valid;
    assign o_delay_ack = w_ack;
    assign o_delay_cur = r_delay_cur;
    assign o_out_p     = w_valid ? w_tap_p : '0;
    assign o_out_n     = w_valid ? w_tap_n : '1;

    // ------------------------------------------------------------------
    // Pair-error checker
    // ------------------------------------------------------------------
`ifdef PAIR_CHECK_EN
    logic [ERR_W-1:0] r_err_count;
    logic             r_err_flag;
    logic             w_pair_err;

    // A healthy pair always has complementary legs.
    assign w_pair_err = |(~(i_in_p ^ i_in_n));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_count <= '0;
            r_err_flag  <= 1'b0;
        end else if (i_err_clr) begin
            r_err_count <= '0;
            r_err_flag  <= 1'b0;
        end else if (w_pair_err) begin
            r_err_flag <= 1'b1;
            if (r_err_count != '1) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign o_err_count = r_err_count;
    assign o_err_flag  = r_err_flag;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = i_err_clr;
    assign o_err_count      = '0;
    assign o_err_flag       = 1'b0;
`endif

endmodule
`default_nettype wire
